// File: rtl/neocore_pkg.sv
// Shared neocore type definitions: ALU operation encodings.
package neocore_pkg;

  // Encodings 9..15 are undefined and behave like ALU_NOP in the ALU.
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_MUL = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_LSH = 4'd7,
    ALU_RSH = 4'd8
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Registered 16-bit unsigned integer ALU for the neocore execute stage.
// One operation per cycle, 1-cycle latency, 32-bit result with zero and
// overflow flags. NOP and undefined encodings hold the output registers.
module alu
  import neocore_pkg::*;
(
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  input  alu_op_e     alu_op,
  output logic [31:0] result,
  output logic        z_flag,
  output logic        v_flag
);

  logic [31:0] a_ext;
  logic [31:0] b_ext;
  logic        shift_oob;   // shift amount of 32 or more clears the result
  logic [31:0] result_next;
  logic        v_next;
  logic        load_next;   // 0 for NOP / undefined encodings: hold outputs

  logic [31:0] result_reg;
  logic        z_reg;
  logic        v_reg;

  assign a_ext     = {16'h0, operand_a};
  assign b_ext     = {16'h0, operand_b};
  assign shift_oob = |operand_b[15:5];

  // Combinational datapath: select the operation result and its overflow flag.
  always_comb begin
    result_next = result_reg;
    v_next      = v_reg;
    load_next   = 1'b1;
    case (alu_op)
      ALU_ADD: begin
        result_next = a_ext + b_ext;
        v_next      = result_next[16];
      end
      ALU_SUB: begin
        // Unsigned subtract saturates at zero; borrow is reported in V.
        if (operand_a >= operand_b) begin
          result_next = a_ext - b_ext;
          v_next      = 1'b0;
        end else begin
          result_next = 32'h0;
          v_next      = 1'b1;
        end
      end
      ALU_MUL: begin
        // Single-cycle 16x16 multiply; this is the critical path.
        result_next = a_ext * b_ext;
        v_next      = |result_next[31:16];
      end
      ALU_AND: begin
        result_next = a_ext & b_ext;
        v_next      = 1'b0;
      end
      ALU_OR: begin
        result_next = a_ext | b_ext;
        v_next      = 1'b0;
      end
      ALU_XOR: begin
        result_next = a_ext ^ b_ext;
        v_next      = 1'b0;
      end
      ALU_LSH: begin
        result_next = shift_oob ? 32'h0 : (a_ext << operand_b[4:0]);
        v_next      = |result_next[31:16];
      end
      ALU_RSH: begin
        result_next = shift_oob ? 32'h0 : (a_ext >> operand_b[4:0]);
        v_next      = 1'b0;
      end
      default: begin
        load_next = 1'b0;
      end
    endcase
  end

  // Output registers: asynchronous clear, load on every defined operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_reg <= 32'h0;
      z_reg      <= 1'b0;
      v_reg      <= 1'b0;
    end else if (load_next) begin
      result_reg <= result_next;
      z_reg      <= (result_next == 32'h0);
      v_reg      <= v_next;
    end
  end

  assign result = result_reg;
  assign z_flag = z_reg;
  assign v_flag = v_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking testbench for the registered neocore ALU: table-driven
// vectors plus hand-written reset, NOP/undefined-hold sequences.
module tb_alu;
  import neocore_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  alu_op_e     alu_op;
  logic [31:0] result;
  logic        z_flag;
  logic        v_flag;

  int n_tests;
  int n_fail;

  typedef struct {
    string       name;
    alu_op_e     op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic        z;
    logic        v;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_op    (alu_op),
    .result    (result),
    .z_flag    (z_flag),
    .v_flag    (v_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] exp_res,
                       input logic exp_z, input logic exp_v);
    n_tests++;
    if (result !== exp_res || z_flag !== exp_z || v_flag !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got result=%08h z=%b v=%b, expected result=%08h z=%b v=%b",
               name, result, z_flag, v_flag, exp_res, exp_z, exp_v);
    end else begin
      $display("ok   %s: result=%08h z=%b v=%b", name, result, z_flag, v_flag);
    end
  endtask

  task automatic apply(input alu_op_e op, input logic [15:0] a, input logic [15:0] b);
    alu_op    = op;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{"add_5_3",        ALU_ADD, 16'h0005, 16'h0003, 32'h0000_0008, 1'b0, 1'b0};
    vecs[1]  = '{"add_carry",      ALU_ADD, 16'hFFFF, 16'h0002, 32'h0001_0001, 1'b0, 1'b1};
    vecs[2]  = '{"add_zero",       ALU_ADD, 16'h0000, 16'h0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3]  = '{"sub_10_5",       ALU_SUB, 16'h0010, 16'h0005, 32'h0000_000B, 1'b0, 1'b0};
    vecs[4]  = '{"sub_equal",      ALU_SUB, 16'h0005, 16'h0005, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{"sub_saturate",   ALU_SUB, 16'h0002, 16'h0005, 32'h0000_0000, 1'b1, 1'b1};
    vecs[6]  = '{"sub_max",        ALU_SUB, 16'hFFFF, 16'h0001, 32'h0000_FFFE, 1'b0, 1'b0};
    vecs[7]  = '{"mul_5_7",        ALU_MUL, 16'h0005, 16'h0007, 32'h0000_0023, 1'b0, 1'b0};
    vecs[8]  = '{"mul_max",        ALU_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b1};
    vecs[9]  = '{"mul_100_100",    ALU_MUL, 16'h0100, 16'h0100, 32'h0001_0000, 1'b0, 1'b1};
    vecs[10] = '{"and",            ALU_AND, 16'hFF00, 16'h0F0F, 32'h0000_0F00, 1'b0, 1'b0};
    vecs[11] = '{"or",             ALU_OR,  16'hF000, 16'h000F, 32'h0000_F00F, 1'b0, 1'b0};
    vecs[12] = '{"xor",            ALU_XOR, 16'hFFFF, 16'hF0F0, 32'h0000_0F0F, 1'b0, 1'b0};
    vecs[13] = '{"xor_self",       ALU_XOR, 16'hAAAA, 16'hAAAA, 32'h0000_0000, 1'b1, 1'b0};
    vecs[14] = '{"lsh_5_2",        ALU_LSH, 16'h0005, 16'h0002, 32'h0000_0014, 1'b0, 1'b0};
    vecs[15] = '{"lsh_8000_1",     ALU_LSH, 16'h8000, 16'h0001, 32'h0001_0000, 1'b0, 1'b1};
    vecs[16] = '{"lsh_ffff_31",    ALU_LSH, 16'hFFFF, 16'h001F, 32'h8000_0000, 1'b0, 1'b1};
    vecs[17] = '{"rsh_14_2",       ALU_RSH, 16'h0014, 16'h0002, 32'h0000_0005, 1'b0, 1'b0};
    vecs[18] = '{"rsh_8000_15",    ALU_RSH, 16'h8000, 16'h000F, 32'h0000_0001, 1'b0, 1'b0};
    vecs[19] = '{"lsh_b_0020",     ALU_LSH, 16'h0005, 16'h0020, 32'h0000_0000, 1'b1, 1'b0};
    vecs[20] = '{"rsh_b_0020",     ALU_RSH, 16'h0005, 16'h0020, 32'h0000_0000, 1'b1, 1'b0};
    vecs[21] = '{"lsh_b_0041",     ALU_LSH, 16'h0005, 16'h0041, 32'h0000_0000, 1'b1, 1'b0};

    // Reset is asynchronous: outputs are zero before any clock edge.
    rst       = 1'b0;
    alu_op    = ALU_ADD;
    operand_a = 16'h1234;
    operand_b = 16'h4321;
    #1;
    check("reset_no_edge", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].res, vecs[i].z, vecs[i].v);
    end

    // NOP holds a nonzero result with V set.
    apply(ALU_MUL, 16'hFFFF, 16'hFFFF);
    check("mul_before_nop", 32'hFFFE_0001, 1'b0, 1'b1);
    apply(ALU_NOP, 16'h0001, 16'h0001);
    check("nop_hold", 32'hFFFE_0001, 1'b0, 1'b1);
    apply(alu_op_e'(4'd12), 16'h0000, 16'h0000);
    check("undef_op_hold", 32'hFFFE_0001, 1'b0, 1'b1);

    // NOP holds a zero result with Z set.
    apply(ALU_SUB, 16'h0003, 16'h0003);
    check("sub_before_nop", 32'h0, 1'b1, 1'b0);
    apply(ALU_NOP, 16'h0007, 16'h0009);
    check("nop_hold_z", 32'h0, 1'b1, 1'b0);

    // Mid-stream reset clears immediately and discards pending inputs.
    apply(ALU_ADD, 16'h0100, 16'h0023);
    check("add_before_rst", 32'h0000_0123, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_clear", 32'h0, 1'b0, 1'b0);
    alu_op    = ALU_ADD;
    operand_a = 16'h0001;
    operand_b = 16'h0001;
    @(posedge clk);
    #1;
    check("rst_discard", 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    apply(ALU_ADD, 16'h0001, 16'h0001);
    check("first_after_rst", 32'h0000_0002, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
